imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the byte-addressed, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and splits each word into four byte writes: byte 0 = bits [7:0] at the lowest address.
- Drives the memory's byte write port, so the memory ends up holding the same layout the fetch path reads.
- Holds `busy` high while loading so the core can be held off until the program image is complete.

Parameters:
- MEM_BYTES, 72, capacity of the target instruction memory in bytes; must be a multiple of 4.
- ADDR_W, 64, width of the memory address, matching the 64-bit instruction address.
- CNT_W, 16, width of the loaded-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; returns the block to the empty state (pointer 0, done/error cleared).
- in_valid  input  1  an instruction word is offered.
- in_ready  output  1  the loader can take a word this cycle.
- in_word  input  32  instruction word.
- in_last  input  1  marks the final word of the image; qualified by in_valid.
- mem_we  output  1  byte write strobe to the instruction memory.
- mem_addr  output  ADDR_W  byte address for the write.
- mem_wdata  output  8  byte data for the write.
- busy  output  1  load in progress: not DONE and not ERR.
- done  output  1  image fully written.
- error  output  1  overflow; a word did not fit in MEM_BYTES.
- word_count  output  CNT_W  number of words fully written.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, wr_ptr=0, byte_idx=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, word_count=0.
  - busy=1 and in_ready=1 immediately after reset release.
  - Reset mid-word abandons the remaining bytes; no further writes occur.
- States: IDLE, WRITE, DONE, ERR.
- All mem_* outputs are registered.
- Handshake: a word transfers on a clock edge where in_valid && in_ready.
  - in_word and in_last are captured at that edge.
  - in_ready = (state==IDLE) || (state==WRITE && byte_idx==3); combinational from state.
- Overflow check at acceptance:
  - If wr_ptr+4 > MEM_BYTES, go to ERR with no writes, error=1, and wr_ptr unchanged.
  - Otherwise go to WRITE with byte_idx=0.
- WRITE, one byte per cycle:
  - mem_we=1, mem_addr=wr_ptr+byte_idx, mem_wdata=word[8*byte_idx+7 : 8*byte_idx].
  - A word accepted at edge T produces writes in cycles T+1..T+4 (addresses ptr..ptr+3).
- End of word, after the byte_idx==3 cycle:
  - wr_ptr += 4 and word_count += 1.
  - If the captured last==1: go to DONE, done=1, mem_we=0.
  - Else, if a new word is handshaken in that same cycle: run the overflow check and continue WRITE with byte_idx=0. This gives back-to-back 4 cycles per word with no bubble.
  - Else: go to IDLE, mem_we=0.
- IDLE, DONE and ERR: mem_we=0; mem_addr and mem_wdata hold their last values.
- DONE and ERR: in_ready=0, and both states are sticky until clear or reset.
- clear: synchronous, takes priority over everything except reset.
  - Forces the reset values (except that busy=1).
  - A clear arriving during WRITE aborts the remaining bytes.
  - A handshake in the same cycle as clear is ignored.
- Overflow boundary with MEM_BYTES=72: the 18th word (ptr 68) writes bytes 68..71; a 19th word raises error.
- in_valid while in_ready=0 is not consumed; the source must hold the word stable.
- word_count saturates at all-ones.

Test Plan:
- Single word: after reset, in_word=0x04BD8463 with in_last=1 -> writes on 4 consecutive cycles:
  - addr0=0x63, addr1=0x84, addr2=0xBD, addr3=0x04.
  - Then done=1, busy=0, word_count=1, in_ready=0.
- Back-to-back: 0x0055_0AB3 then 0x0065_0B33 (last) held valid -> 8 contiguous mem_we cycles:
  - addr4..7 = B3,0A,55,00 after the first word, then addr8..11 = 33,0B,65,00.
  - in_ready high only in IDLE and in each byte_idx==3 cycle.
- Stalled source: in_valid drops between words -> mem_we=0 gap; the next word resumes at the correct wr_ptr with no duplicate or skipped address.
- Overflow: stream 19 words with none marked last -> 72 bytes written (addr 0..71), word_count=18, error=1, no write to addr 72, busy=0.
- clear mid-word: assert clear during the byte_idx==1 cycle -> mem_we=0 on the next cycle, wr_ptr=0, word_count=0; the next word writes from addr 0.
- Async reset mid-word: pull reset_n low between clock edges during WRITE -> outputs go to their reset values immediately without waiting for a clock edge, and no further writes occur.

Source files
------------

// File: rtl/imem_loader.sv
// Writer side of the byte-addressed instruction memory: takes 32-bit words over a
// valid/ready stream and writes them little-endian, one byte per cycle.
module imem_loader #(
    parameter int MEM_BYTES = 72,
    parameter int ADDR_W    = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  word_count
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [1:0]        byte_idx;
    logic              last_q;
    logic [31:0]       word_q;

    logic              word_end;
    logic              accept;
    logic              fits;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] accept_ptr;
    logic [1:0]        byte_nxt;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        word_end   = (state == WRITE) && (byte_idx == 2'd3);
        in_ready   = (state == IDLE) || word_end;
        busy       = (state != DONE) && (state != ERR);
        ptr_next   = wr_ptr + WORD_BYTES;
        // A word offered in the last byte cycle lands right after the current one.
        accept_ptr = word_end ? ptr_next : wr_ptr;
        fits       = (accept_ptr + WORD_BYTES) <= MEM_LIMIT;
        accept     = in_valid && in_ready && !(word_end && last_q);
        byte_nxt   = byte_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            word_q <= in_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            byte_idx   <= 2'd0;
            last_q     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else if (clear) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            byte_idx   <= 2'd0;
            last_q     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) begin
                if (fits) begin
                    state     <= WRITE;
                    byte_idx  <= 2'd0;
                    last_q    <= in_last;
                    mem_we    <= 1'b1;
                    mem_addr  <= accept_ptr;
                    mem_wdata <= in_word[7:0];
                end else begin
                    state  <= ERR;
                    error  <= 1'b1;
                    mem_we <= 1'b0;
                end
            end else begin
                case (state)
                    WRITE: begin
                        if (!word_end) begin
                            byte_idx  <= byte_nxt;
                            mem_addr  <= wr_ptr + ADDR_W'(byte_nxt);
                            mem_wdata <= byte_sel(word_q, byte_nxt);
                        end else if (last_q) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            mem_we <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            mem_we <= 1'b0;
                        end
                    end
                    default: mem_we <= 1'b0;
                endcase
            end

            if (word_end) begin
                wr_ptr     <= ptr_next;
                word_count <= sat_inc(word_count);
            end
        end
    end
endmodule
